// File: rtl/grf_write_arbiter_pkg.sv
// Shared types for the GRF write-port arbiter.
// Defines the write-request payload, the register-zero constant, and the FIFO
// entry type. The FIFO entry type gains an age stamp when ARB_TRACE_EN is defined.
package grf_write_arbiter_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;

    localparam logic [REG_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [REG_W-1:0]  a3;
        logic [DATA_W-1:0] wd;
        logic [DATA_W-1:0] pc;
    } wr_req_t;

`ifdef ARB_TRACE_EN
    localparam int unsigned AGE_W = 32;

    // The age field holds the cycle stamp taken at push time.
    typedef struct packed {
        wr_req_t          req;
        logic [AGE_W-1:0] age;
    } fifo_ent_t;
`else
    typedef struct packed {
        wr_req_t req;
    } fifo_ent_t;
`endif

endpackage

// File: rtl/grf_write_arbiter_wr_fifo.sv
// In-order circular FIFO that buffers deferred L writes.
// Ports: clk, reset (async active-low), push/push_data, pop, head (entry at rd
// pointer), full/empty (from registered count only).
module grf_write_arbiter_wr_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter type         entry_t = logic
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t head,
    output logic   full,
    output logic   empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   cnt;
    logic               push_ok;
    logic               pop_ok;

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage needs no reset; empty gates every consumer of head.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/grf_write_arbiter.sv
// Shares the single GRF write port between the writeback stage (W, never
// stalled, highest priority) and the long-latency unit (L, valid/ready).
// L writes are queued and drained into idle port cycles; a per-register pending
// scoreboard drives busy1/busy2, and stall_req requests a writeback bubble when
// the queue has been blocked for STARVE_LIMIT cycles.
// Ports: clk, reset (async active-low); wb_* writeback request; lu_* L request
// with lu_ready; grf_* granted write (combinational); chk_a1/chk_a2 -> busy1/busy2;
// stall_req (registered).
// Optional: define ARB_TRACE_EN to print each deferred write with its residency.
module grf_write_arbiter
    import grf_write_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_we,
    input  logic [REG_W-1:0]  wb_a3,
    input  logic [DATA_W-1:0] wb_wd,
    input  logic [DATA_W-1:0] wb_pc,
    input  logic              lu_valid,
    output logic              lu_ready,
    input  logic [REG_W-1:0]  lu_a3,
    input  logic [DATA_W-1:0] lu_wd,
    input  logic [DATA_W-1:0] lu_pc,
    output logic              grf_we,
    output logic [REG_W-1:0]  grf_a3,
    output logic [DATA_W-1:0] grf_wd,
    output logic [DATA_W-1:0] grf_pc,
    input  logic [REG_W-1:0]  chk_a1,
    input  logic [REG_W-1:0]  chk_a2,
    output logic              busy1,
    output logic              busy2,
    output logic              stall_req
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned NREG  = 1 << REG_W;
    localparam int unsigned SW    = $clog2(STARVE_LIMIT + 1);

    logic                        w_claim;
    logic                        push;
    logic                        pop;
    logic                        full;
    logic                        empty;
    fifo_ent_t                   push_ent;
    fifo_ent_t                   head;
    logic [NREG-1:0]             push_hit;
    logic [NREG-1:0]             pop_hit;
    logic [NREG-1:0][CNT_W-1:0]  pend;
    logic [SW-1:0]               starve_cnt;
    logic [SW-1:0]               starve_nxt;

    // A write to $0 never occupies the port.
    assign w_claim  = wb_we && (wb_a3 != REG_ZERO);
    assign lu_ready = !full;
    assign push     = lu_valid && lu_ready && (lu_a3 != REG_ZERO);
    assign pop      = !w_claim && !empty;

`ifdef ARB_TRACE_EN
    logic [AGE_W-1:0] cyc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc <= '0;
        end else begin
            cyc <= cyc + AGE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset && pop) begin
            $display("%d@%h: defer $%d <= %h (%0d cyc)", $time, head.req.pc,
                     head.req.a3, head.req.wd, cyc - head.age);
        end
    end
`endif

    // Build the queued entry from the L request.
    always_comb begin
        push_ent        = '0;
        push_ent.req.a3 = lu_a3;
        push_ent.req.wd = lu_wd;
        push_ent.req.pc = lu_pc;
`ifdef ARB_TRACE_EN
        push_ent.age    = cyc;
`endif
    end

    grf_write_arbiter_wr_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (fifo_ent_t)
    ) u_wr_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_ent),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    // Port grant: W first, otherwise the queue head.
    always_comb begin
        grf_we = 1'b0;
        grf_a3 = '0;
        grf_wd = '0;
        grf_pc = '0;
        if (w_claim) begin
            grf_we = 1'b1;
            grf_a3 = wb_a3;
            grf_wd = wb_wd;
            grf_pc = wb_pc;
        end else if (!empty) begin
            grf_we = 1'b1;
            grf_a3 = head.req.a3;
            grf_wd = head.req.wd;
            grf_pc = head.req.pc;
        end
    end

    // One-hot register hits for this cycle's push and pop.
    always_comb begin
        push_hit = '0;
        pop_hit  = '0;
        if (push) begin
            push_hit[lu_a3] = 1'b1;
        end
        if (pop) begin
            pop_hit[head.req.a3] = 1'b1;
        end
    end

    // Pending-write counters; entry 0 is never touched and stays zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend <= '0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (push_hit[r] && !pop_hit[r]) begin
                    pend[r] <= pend[r] + CNT_W'(1);
                end else if (pop_hit[r] && !push_hit[r]) begin
                    pend[r] <= pend[r] - CNT_W'(1);
                end
            end
        end
    end

    assign busy1 = (pend[chk_a1] != '0) ||
                   (lu_valid && (lu_a3 == chk_a1) && (chk_a1 != REG_ZERO));
    assign busy2 = (pend[chk_a2] != '0) ||
                   (lu_valid && (lu_a3 == chk_a2) && (chk_a2 != REG_ZERO));

    // Starvation counter: saturates while the queue is blocked by W.
    always_comb begin
        starve_nxt = starve_cnt;
        if (empty || pop) begin
            starve_nxt = '0;
        end else if (w_claim && (starve_cnt != SW'(STARVE_LIMIT))) begin
            starve_nxt = starve_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
            stall_req  <= 1'b0;
        end else begin
            starve_cnt <= starve_nxt;
            stall_req  <= (starve_nxt == SW'(STARVE_LIMIT));
        end
    end

`ifndef SYNTHESIS
    // The hazard unit must keep W away from registers with queued L writes.
    waw_order: assert property (@(posedge clk) disable iff (!reset)
        w_claim |-> (pend[wb_a3] == '0));
`endif

endmodule

// File: tb/tb_grf_write_arbiter.sv
module tb_grf_write_arbiter;

    localparam int DEPTH = 4;
    localparam int LIMIT = 3;

    logic        clk;
    logic        reset;
    logic        wb_we;
    logic [4:0]  wb_a3;
    logic [31:0] wb_wd;
    logic [31:0] wb_pc;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_a3;
    logic [31:0] lu_wd;
    logic [31:0] lu_pc;
    logic        grf_we;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd;
    logic [31:0] grf_pc;
    logic [4:0]  chk_a1;
    logic [4:0]  chk_a2;
    logic        busy1;
    logic        busy2;
    logic        stall_req;

    grf_write_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .wb_we     (wb_we),
        .wb_a3     (wb_a3),
        .wb_wd     (wb_wd),
        .wb_pc     (wb_pc),
        .lu_valid  (lu_valid),
        .lu_ready  (lu_ready),
        .lu_a3     (lu_a3),
        .lu_wd     (lu_wd),
        .lu_pc     (lu_pc),
        .grf_we    (grf_we),
        .grf_a3    (grf_a3),
        .grf_wd    (grf_wd),
        .grf_pc    (grf_pc),
        .chk_a1    (chk_a1),
        .chk_a2    (chk_a2),
        .busy1     (busy1),
        .busy2     (busy2),
        .stall_req (stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] pc;
    } req_t;

    typedef struct {
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] pc;
        logic        rdy;
        logic        b1;
        logic        b2;
        logic        st;
    } exp_t;

    // Reference model: queue of deferred writes plus starvation bookkeeping.
    req_t        mq[$];
    exp_t        exp_q[$];
    int          m_blocked;
    logic        m_stall;
    logic        held;
    req_t        h_req;

    int n_checks;
    int n_pass;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic int pend_of(input logic [4:0] r);
        int n = 0;
        foreach (mq[i]) if (mq[i].a3 == r) n++;
        return n;
    endfunction

    // Called at posedge+1: drives one cycle, queues its expected response,
    // advances the model, and returns at the next posedge+1.
    task automatic drive_cycle(input logic we, input logic [4:0] a3,
                               input logic [31:0] wd, input logic [31:0] pc,
                               input logic lv, input logic [4:0] la3,
                               input logic [31:0] lwd, input logic [31:0] lpc,
                               input logic [4:0] c1, input logic [4:0] c2);
        exp_t e;
        logic claim;
        logic acc;
        logic do_pop;
        logic empty0;
        if (m_stall) we = 1'b0;
        if (we && a3 != 0 && pend_of(a3) != 0) we = 1'b0;
        if (held) begin
            lv = 1'b1; la3 = h_req.a3; lwd = h_req.wd; lpc = h_req.pc;
        end
        wb_we = we; wb_a3 = a3; wb_wd = wd; wb_pc = pc;
        lu_valid = lv; lu_a3 = la3; lu_wd = lwd; lu_pc = lpc;
        chk_a1 = c1; chk_a2 = c2;

        claim  = we && (a3 != 0);
        empty0 = (mq.size() == 0);
        e.rdy  = (mq.size() < DEPTH);
        e.st   = m_stall;
        e.b1   = (c1 != 0) && (pend_of(c1) != 0 || (lv && la3 == c1));
        e.b2   = (c2 != 0) && (pend_of(c2) != 0 || (lv && la3 == c2));
        if (claim) begin
            e.we = 1'b1; e.a3 = a3; e.wd = wd; e.pc = pc;
        end else if (!empty0) begin
            e.we = 1'b1; e.a3 = mq[0].a3; e.wd = mq[0].wd; e.pc = mq[0].pc;
        end else begin
            e.we = 1'b0; e.a3 = '0; e.wd = '0; e.pc = '0;
        end
        exp_q.push_back(e);

        acc    = lv && e.rdy;
        do_pop = !claim && !empty0;
        if (do_pop) void'(mq.pop_front());
        if (acc && la3 != 0) mq.push_back('{a3: la3, wd: lwd, pc: lpc});
        if (empty0 || do_pop) m_blocked = 0;
        else if (m_blocked < LIMIT) m_blocked++;
        m_stall = (m_blocked >= LIMIT);
        held = lv && !acc;
        h_req = '{a3: la3, wd: lwd, pc: lpc};

        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle(input logic [4:0] c1);
        drive_cycle(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, c1, 5'd0);
    endtask

    // Monitor: compares the DUT's presented outputs mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("grf_we",    32'(grf_we),    32'(e.we));
                check("grf_a3",    32'(grf_a3),    32'(e.a3));
                check("grf_wd",    grf_wd,         e.wd);
                check("grf_pc",    grf_pc,         e.pc);
                check("lu_ready",  32'(lu_ready),  32'(e.rdy));
                check("busy1",     32'(busy1),     32'(e.b1));
                check("busy2",     32'(busy2),     32'(e.b2));
                check("stall_req", 32'(stall_req), 32'(e.st));
            end
        end
    end

    initial begin
        n_checks = 0; n_pass = 0;
        m_blocked = 0; m_stall = 1'b0; held = 1'b0;
        h_req = '{a3: 5'd0, wd: 32'd0, pc: 32'd0};
        reset = 1'b0;
        wb_we = 1'b0; wb_a3 = '0; wb_wd = '0; wb_pc = '0;
        lu_valid = 1'b0; lu_a3 = '0; lu_wd = '0; lu_pc = '0;
        chk_a1 = 5'd5; chk_a2 = 5'd0;

        #2;
        check("reset_grf_we",    32'(grf_we),    32'd0);
        check("reset_grf_wd",    grf_wd,         32'd0);
        check("reset_lu_ready",  32'(lu_ready),  32'd1);
        check("reset_stall_req", 32'(stall_req), 32'd0);
        #10;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // W-only write on an idle port.
        drive_cycle(1'b1, 5'd5, 32'h1234, 32'h100, 1'b0, 5'd0, 32'd0, 32'd0, 5'd5, 5'd0);

        // L write of $8 drains into the next idle cycle.
        drive_cycle(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd8, 32'hAAAA, 32'h200, 5'd8, 5'd0);
        idle_cycle(5'd8);
        idle_cycle(5'd8);

        // Fill the queue while W writes every cycle, then let starvation drain it.
        for (int i = 0; i < 4; i++)
            drive_cycle(1'b1, 5'(1 + i), 32'(i), 32'h300 + 32'(i),
                        1'b1, 5'(10 + i), 32'hB000 + 32'(i), 32'h400 + 32'(i),
                        5'(10 + i), 5'd10);
        for (int i = 0; i < 14; i++)
            drive_cycle(1'b1, 5'(20 + (i % 4)), 32'hC000 + 32'(i), 32'h500 + 32'(i),
                        1'b1, 5'd14, 32'hD00D, 32'h600, 5'd14, 5'd13);
        while (mq.size() != 0 || held) idle_cycle(5'd14);

        // L write to $0 is accepted but never granted.
        drive_cycle(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD, 32'h700, 5'd0, 5'd0);
        idle_cycle(5'd0);
        idle_cycle(5'd0);

        // Queue three writes, then reset asynchronously.
        for (int i = 0; i < 3; i++)
            drive_cycle(1'b1, 5'(1 + i), 32'(i), 32'h800, 1'b1, 5'(20 + i),
                        32'hE000 + 32'(i), 32'h900 + 32'(i), 5'd20, 5'd0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        wb_we = 1'b0;
        lu_valid = 1'b0;
        chk_a1 = 5'd20;
        #1;
        check("async_rst_grf_we",   32'(grf_we),    32'd0);
        check("async_rst_lu_ready", 32'(lu_ready),  32'd1);
        check("async_rst_busy1",    32'(busy1),     32'd0);
        check("async_rst_stall",    32'(stall_req), 32'd0);
        mq.delete();
        m_blocked = 0; m_stall = 1'b0; held = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) idle_cycle(5'd20);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            logic       we;
            logic       lv;
            logic [4:0] a3;
            logic [4:0] la3;
            logic [4:0] c1;
            logic [4:0] c2;
            we  = ($urandom_range(0, 99) < 55);
            a3  = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            lv  = ($urandom_range(0, 99) < 50);
            la3 = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            c1  = (mq.size() != 0 && $urandom_range(0, 1) == 1) ? mq[0].a3
                                                                 : 5'($urandom_range(0, 31));
            c2  = (mq.size() != 0 && $urandom_range(0, 1) == 1) ? mq[mq.size() - 1].a3
                                                                 : 5'($urandom_range(0, 31));
            drive_cycle(we, a3, $urandom, $urandom, lv, la3, $urandom, $urandom, c1, c2);
        end

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
